mips_mc_ctrl: RTL and testbench

Multi-cycle sequencer for the MIPS datapath. It drives a single shared memory port for both instruction fetch and data access, using a req/ready handshake. It consumes the instruction decoder's class outputs and produces per-cycle datapath strobes (IR, address, MDR, register file, PC). This turns the single-cycle datapath into a multi-cycle machine that tolerates wait-stated memory.

---
 rtl/mips_mc_ctrl_pkg.sv | 36 +++
 rtl/mips_mc_ctrl_if.sv | 27 ++
 rtl/mc_wait_watchdog.sv | 36 +++
 rtl/mips_mc_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS sequencer.
// Optional perf counters are enabled by defining MC_CTRL_PERF_EN.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ADDR,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic WB_ALU   = 1'b0;
    localparam logic WB_MEM   = 1'b1;
    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_REG = 1'b1;

    localparam int LAT_ALU   = 3;
    localparam int LAT_STORE = 4;
    localparam int LAT_LOAD  = 5;

    typedef struct packed {
        logic writeenable;
        logic word_we;
        logic byte_we;
        logic byte_load;
        logic addm;
    } dec_t;

    function automatic logic is_store(dec_t d);
        return d.word_we | d.byte_we;
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Shared memory port between the sequencer and memory.
// Request fields hold steady from raise until the mem_ready cycle.
interface mips_mc_ctrl_if;

    logic mem_req;
    logic mem_wr;
    logic mem_byte;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_byte,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_byte,
        input  mem_addr_sel,
        output mem_ready
    );

endinterface

// File: rtl/mc_wait_watchdog.sv
// Counts consecutive unanswered request cycles; flags timeout on the
// cycle the count would reach MEM_WAIT_MAX. MEM_WAIT_MAX = 0 disables it.
module mc_wait_watchdog #(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_req,
    input  logic mem_ready,
    output logic timeout
);

    localparam int W = (MEM_WAIT_MAX > 2) ? $clog2(MEM_WAIT_MAX) : 1;

    logic [W-1:0] cnt;
    logic         waiting;

    assign waiting = mem_req & ~mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (waiting) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    if (MEM_WAIT_MAX == 0) begin : g_off
        assign timeout = 1'b0;
    end else begin : g_on
        assign timeout = waiting & (cnt == W'(MEM_WAIT_MAX - 1));
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle sequencer: one shared memory port, wait-state tolerant.
// Define MC_CTRL_PERF_EN to add cycle_cnt / instr_cnt counters.
module mips_mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 255,
    parameter int CNT_W        = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic except,
    input  logic writeenable,
    input  logic mem_read,
    input  logic word_we,
    input  logic byte_we,
    input  logic byte_load,
    input  logic addm,
    mips_mc_ctrl_if.master mem,
    output logic ir_we,
    output logic addr_we,
    output logic mdr_we,
    output logic reg_we,
    output logic wb_sel,
    output logic alu_b_mdr,
    output logic pc_we,
    output logic retire,
    output logic halted,
    output logic bus_err
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_t state, state_n;
    dec_t   dec_in, dec_q;
    logic   req_raw;
    logic   timeout;
    logic   bus_err_q;

    assign dec_in = '{
        writeenable: writeenable,
        word_we:     word_we,
        byte_we:     byte_we,
        byte_load:   byte_load,
        addm:        addm
    };

    // Request depends on state only, so the watchdog sees no comb loop.
    assign req_raw = ~reset & (state == S_FETCH || state == S_MEM);

    mc_wait_watchdog #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (req_raw),
        .mem_ready (mem.mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            dec_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_n;
            bus_err_q <= bus_err_q | timeout;
            if (state == S_DECODE) begin
                dec_q <= dec_in;
            end
        end
    end

    always_comb begin
        state_n          = state;
        mem.mem_req      = 1'b0;
        mem.mem_wr       = 1'b0;
        mem.mem_byte     = 1'b0;
        mem.mem_addr_sel = ADDR_PC;
        ir_we            = 1'b0;
        addr_we          = 1'b0;
        mdr_we           = 1'b0;
        reg_we           = 1'b0;
        wb_sel           = WB_ALU;
        alu_b_mdr        = 1'b0;
        pc_we            = 1'b0;
        retire           = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_we   = 1'b1;
                    state_n = S_DECODE;
                end else if (timeout) begin
                    state_n = S_HALT;
                end
            end
            S_DECODE: begin
                if (except) begin
                    state_n = S_HALT;
                end else if (mem_read | word_we | byte_we) begin
                    state_n = S_ADDR;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_we   = 1'b1;
                reg_we  = dec_q.writeenable;
                retire  = 1'b1;
                state_n = S_FETCH;
            end
            S_ADDR: begin
                addr_we = 1'b1;
                state_n = S_MEM;
            end
            S_MEM: begin
                mem.mem_req      = 1'b1;
                mem.mem_addr_sel = ADDR_REG;
                mem.mem_wr       = is_store(dec_q);
                mem.mem_byte     = dec_q.byte_we | dec_q.byte_load;
                if (mem.mem_ready) begin
                    if (is_store(dec_q)) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        mdr_we  = 1'b1;
                        state_n = S_WB;
                    end
                end else if (timeout) begin
                    state_n = S_HALT;
                end
            end
            S_WB: begin
                reg_we    = 1'b1;
                pc_we     = 1'b1;
                retire    = 1'b1;
                alu_b_mdr = dec_q.addm;
                wb_sel    = dec_q.addm ? WB_ALU : WB_MEM;
                state_n   = S_FETCH;
            end
            S_HALT: begin
                state_n = S_HALT;
            end
            default: begin
                state_n = S_HALT;
            end
        endcase
        // Reset silences everything, including a request in flight.
        if (reset) begin
            mem.mem_req      = 1'b0;
            mem.mem_wr       = 1'b0;
            mem.mem_byte     = 1'b0;
            mem.mem_addr_sel = ADDR_PC;
            ir_we            = 1'b0;
            addr_we          = 1'b0;
            mdr_we           = 1'b0;
            reg_we           = 1'b0;
            wb_sel           = WB_ALU;
            alu_b_mdr        = 1'b0;
            pc_we            = 1'b0;
            retire           = 1'b0;
        end
    end

    assign halted  = ~reset & (state == S_HALT);
    assign bus_err = ~reset & bus_err_q;

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] cyc_q, ins_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            if (retire) begin
                ins_q <= ins_q + 1'b1;
            end
        end
    end

    assign cycle_cnt = reset ? '0 : cyc_q;
    assign instr_cnt = reset ? '0 : ins_q;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: per-instruction expected strobe schedule
// derived from instruction class and wait counts, checked every cycle.
module tb_mips_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic except, writeenable, mem_read, word_we, byte_we, byte_load, addm;
    logic ir_we, addr_we, mdr_we, reg_we, wb_sel, alu_b_mdr;
    logic pc_we, retire, halted, bus_err;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    always #5 clk = ~clk;

    mips_mc_ctrl_if bus ();

    mips_mc_ctrl #(
        .MEM_WAIT_MAX (4),
        .CNT_W        (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .except      (except),
        .writeenable (writeenable),
        .mem_read    (mem_read),
        .word_we     (word_we),
        .byte_we     (byte_we),
        .byte_load   (byte_load),
        .addm        (addm),
        .mem         (bus),
        .ir_we       (ir_we),
        .addr_we     (addr_we),
        .mdr_we      (mdr_we),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .alu_b_mdr   (alu_b_mdr),
        .pc_we       (pc_we),
        .retire      (retire),
        .halted      (halted),
        .bus_err     (bus_err)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    typedef struct packed {
        logic req, wr, byt, asel;
        logic ir, aw, mdr, rw, wbs, bm, pc, ret, h, be;
    } obs_t;

    typedef struct packed {
        logic ex, we, rd, ww, bw, bl, am;
    } ins_t;

    localparam ins_t NOP  = 7'b0000000;
    localparam ins_t ADD  = 7'b0100000;
    localparam ins_t BEQ  = 7'b0000000;
    localparam ins_t LW   = 7'b0110000;
    localparam ins_t LBU  = 7'b0110010;
    localparam ins_t ADDM = 7'b0110001;
    localparam ins_t SW   = 7'b0001000;
    localparam ins_t SB   = 7'b0000100;
    localparam ins_t ILL  = 7'b1000000;

    obs_t  act, exp_v;
    logic  chk = 1'b0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    icyc = 0;
    int    ret_cyc = -1;
    string tag = "init";

    assign act = {bus.mem_req, bus.mem_wr, bus.mem_byte, bus.mem_addr_sel,
                  ir_we, addr_we, mdr_we, reg_we, wb_sel, alu_b_mdr,
                  pc_we, retire, halted, bus_err};

    always @(negedge clk) begin
        if (chk) begin
            n_chk++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %b want %b", tag, icyc, act, exp_v);
            end
            if (act.ret === 1'b1) ret_cyc = icyc;
        end
    end

    task automatic step(input logic rdy, input logic rst, input ins_t d,
                        input obs_t e);
        @(posedge clk);
        #1;
        reset = rst;
        bus.mem_ready = rdy;
        {except, writeenable, mem_read, word_we, byte_we, byte_load, addm} = d;
        exp_v = e;
        chk = 1'b1;
        icyc++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, NOP, '0);
    endtask

    // Expected schedule: fetch(+fw waits), decode, then class-specific tail.
    task automatic run(input string t, input ins_t d, input int fw,
                       input int dw, input int halt_n);
        obs_t e;
        logic st;
        tag = t;
        icyc = 0;
        ret_cyc = -1;
        st = d.ww | d.bw;
        for (int i = 0; i <= fw; i++) begin
            e = '0; e.req = 1'b1; e.ir = (i == fw);
            step(i == fw, 1'b0, NOP, e);
        end
        step(1'b0, 1'b0, d, '0);
        if (d.ex) begin
            for (int i = 0; i < halt_n; i++) begin
                e = '0; e.h = 1'b1;
                step(1'b1, 1'b0, d, e);
            end
        end else if (d.rd | st) begin
            e = '0; e.aw = 1'b1;
            step(1'b0, 1'b0, d, e);
            for (int i = 0; i <= dw; i++) begin
                e = '0; e.req = 1'b1; e.asel = 1'b1;
                e.wr = st; e.byt = d.bw | d.bl;
                if (i == dw) begin
                    if (st) begin e.pc = 1'b1; e.ret = 1'b1; end
                    else e.mdr = 1'b1;
                end
                step(i == dw, 1'b0, d, e);
            end
            if (!st) begin
                e = '0; e.rw = 1'b1; e.pc = 1'b1; e.ret = 1'b1;
                e.bm = d.am; e.wbs = ~d.am;
                step(1'b0, 1'b0, d, e);
            end
        end else begin
            e = '0; e.pc = 1'b1; e.ret = 1'b1; e.rw = d.we;
            step(1'b0, 1'b0, d, e);
        end
    endtask

    task automatic check_lat(input string t, input int want);
        @(negedge clk);
        #1;
        n_chk++;
        if (ret_cyc != want) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", t, ret_cyc, want);
        end
    endtask

    initial begin
        obs_t e;
        bus.mem_ready = 1'b0;
        {except, writeenable, mem_read, word_we, byte_we, byte_load, addm} = '0;
        exp_v = '0;

        tag = "reset";
        do_reset(2);
        run("add", ADD, 0, 0, 0);    check_lat("add", 3);
        run("lw", LW, 2, 2, 0);      check_lat("lw", 9);
        run("addm", ADDM, 0, 0, 0);  check_lat("addm", 5);
        run("sw", SW, 1, 0, 0);      check_lat("sw", 5);
        run("beq", BEQ, 0, 0, 0);    check_lat("beq", 3);
        run("lbu", LBU, 1, 1, 0);    check_lat("lbu", 7);
        run("sb", SB, 0, 1, 0);      check_lat("sb", 5);
        run("ill", ILL, 0, 0, 4);    check_lat("ill", -1);

        tag = "rst_halt";
        do_reset(1);
        run("add2", ADD, 0, 0, 0);   check_lat("add2", 3);

        tag = "midrst";
        for (int i = 0; i < 2; i++) begin
            e = '0; e.req = 1'b1;
            step(1'b0, 1'b0, NOP, e);
        end
        do_reset(2);

        tag = "wdog";
        icyc = 0;
        ret_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            e = '0; e.req = 1'b1;
            step(1'b0, 1'b0, NOP, e);
        end
        for (int i = 0; i < 3; i++) begin
            e = '0; e.h = 1'b1; e.be = 1'b1;
            step(1'b1, 1'b0, NOP, e);
        end
        check_lat("wdog", -1);

        tag = "rst_wdog";
        do_reset(1);
        run("add3", ADD, 0, 0, 0);   check_lat("add3", 3);

`ifdef MC_CTRL_PERF_EN
        tag = "rst_perf";
        do_reset(1);
        for (int i = 0; i < 10; i++) run("perf", ADD, 0, 0, 0);
        @(posedge clk);
        #1;
        chk = 1'b0;
        n_chk++;
        if (instr_cnt !== 32'd10) begin
            n_fail++;
            $display("FAIL instr_cnt: got %0d want 10", instr_cnt);
        end
        n_chk++;
        if (cycle_cnt !== 32'd30) begin
            n_fail++;
            $display("FAIL cycle_cnt: got %0d want 30", cycle_cnt);
        end
`endif

        @(posedge clk);
        #1;
        chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
